// File: rtl/plt_landing_scheduler.sv
// Time-multiplexed landing scheduler: one (player, platform) crossing test per clock, first hit per player wins.
// Latency 2*NUM_PLT+1 cycles from an accepted start to done; start is ignored while busy, nothing is queued.
module plt_landing_scheduler #(
  parameter int WIDTH   = 23,
  parameter int HEIGHT  = 30,
  parameter int NUM_PLT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [9:0]                 p1_x,
  input  logic [9:0]                 p1_y,
  input  logic [9:0]                 p1_next_y,
  input  logic [9:0]                 p2_x,
  input  logic [9:0]                 p2_y,
  input  logic [9:0]                 p2_next_y,
  output logic                       busy,
  output logic                       done,
  output logic                       p1_land,
  output logic                       p2_land,
  output logic [$clog2(NUM_PLT)-1:0] p1_plt,
  output logic [$clog2(NUM_PLT)-1:0] p2_plt,
  output logic [9:0]                 p1_land_y,
  output logic [9:0]                 p2_land_y
);

  localparam int PW   = $clog2(NUM_PLT);
  localparam int CW   = $clog2(2 * NUM_PLT);
  localparam int LAST = 2 * NUM_PLT - 1;

  localparam logic [10:0] PLT_X [4] = '{11'd120, 11'd415, 11'd267, 11'd80};
  localparam logic [10:0] PLT_Y [4] = '{11'd215, 11'd215, 11'd140, 11'd380};
  localparam logic [10:0] PLT_W [4] = '{11'd105, 11'd105, 11'd105, 11'd480};

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] next_y;
  } pos_t;

  typedef struct packed {
    logic          land;
    logic [PW-1:0] plt;
    logic [9:0]    land_y;
  } res_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  pos_t          snap     [2];
  res_t          work     [2];
  res_t          work_nxt [2];
  res_t          res      [2];

  logic          cur_player;
  logic [CW-1:0] plt_sel;
  logic [PW-1:0] cur_plt;
  pos_t          cur;
  logic [10:0]   px, py, pw;
  logic          hit;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (cnt == CW'(LAST)) state_nxt = DONE;
      DONE:    state_nxt = start ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // All terms widened to 11 bits so y+2H near the top of the 10-bit range cannot wrap into a false hit.
  always_comb begin
    cur_player = (cnt >= CW'(NUM_PLT));
    plt_sel    = cur_player ? cnt - CW'(NUM_PLT) : cnt;
    cur_plt    = plt_sel[PW-1:0];
    cur        = snap[cur_player];
    px         = PLT_X[cur_plt];
    py         = PLT_Y[cur_plt];
    pw         = PLT_W[cur_plt];
    hit        = ({1'b0, cur.y}      + 11'(2 * HEIGHT) <= py) &&
                 ({1'b0, cur.next_y} + 11'(2 * HEIGHT) >= py) &&
                 ({1'b0, cur.x}      + 11'(2 * WIDTH)  >= px) &&
                 ({1'b0, cur.x} <= px + pw);
    work_nxt[0] = work[0];
    work_nxt[1] = work[1];
    if (state == SCAN && hit && !work[cur_player].land) begin
      work_nxt[cur_player].land   = 1'b1;
      work_nxt[cur_player].plt    = cur_plt;
      work_nxt[cur_player].land_y = 10'(py - 11'(2 * HEIGHT));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      snap[0] <= '0;
      snap[1] <= '0;
      work[0] <= '0;
      work[1] <= '0;
      res[0]  <= '0;
      res[1]  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == SCAN);
      done  <= (state_nxt == DONE);
      if (state != SCAN && state_nxt == SCAN) begin
        cnt     <= '0;
        snap[0] <= '{x: p1_x, y: p1_y, next_y: p1_next_y};
        snap[1] <= '{x: p2_x, y: p2_y, next_y: p2_next_y};
        work[0] <= '0;
        work[1] <= '0;
      end else if (state == SCAN) begin
        cnt     <= cnt + CW'(1);
        work[0] <= work_nxt[0];
        work[1] <= work_nxt[1];
        // The last pair's verdict is folded in on the same edge the results are published.
        if (state_nxt == DONE) begin
          res[0] <= work_nxt[0];
          res[1] <= work_nxt[1];
        end
      end
    end
  end

  assign p1_land   = res[0].land;
  assign p1_plt    = res[0].plt;
  assign p1_land_y = res[0].land_y;
  assign p2_land   = res[1].land;
  assign p2_plt    = res[1].plt;
  assign p2_land_y = res[1].land_y;

endmodule

// File: tb/tb_plt_landing_scheduler.sv
// Bench for plt_landing_scheduler: directed literal cases plus randomized start/reset/position traffic
// checked every cycle against a cycle-count reference model of the scan.
module tb_plt_landing_scheduler;
  localparam int W = 23;
  localparam int H = 30;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] p1_x = '0, p1_y = '0, p1_next_y = '0;
  logic [9:0] p2_x = '0, p2_y = '0, p2_next_y = '0;
  logic       busy, done, p1_land, p2_land;
  logic [1:0] p1_plt, p2_plt;
  logic [9:0] p1_land_y, p2_land_y;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  plt_landing_scheduler #(.WIDTH(W), .HEIGHT(H), .NUM_PLT(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .p1_x(p1_x), .p1_y(p1_y), .p1_next_y(p1_next_y),
    .p2_x(p2_x), .p2_y(p2_y), .p2_next_y(p2_next_y),
    .busy(busy), .done(done),
    .p1_land(p1_land), .p2_land(p2_land),
    .p1_plt(p1_plt), .p2_plt(p2_plt),
    .p1_land_y(p1_land_y), .p2_land_y(p2_land_y)
  );

  int tbl_x [4] = '{120, 415, 267, 80};
  int tbl_y [4] = '{215, 215, 140, 380};
  int tbl_w [4] = '{105, 105, 105, 480};

  typedef struct {
    bit land;
    int plt;
    int ly;
  } mres_t;

  mres_t m_out  [2];
  mres_t m_pend [2];
  int    m_left = 0;
  bit    m_done = 1'b0;

  function automatic mres_t model_land(input int x, input int y, input int ny);
    mres_t r;
    r.land = 1'b0; r.plt = 0; r.ly = 0;
    for (int i = 0; i < 4; i++)
      if (!r.land && y + 2*H <= tbl_y[i] && ny + 2*H >= tbl_y[i] &&
          x + 2*W >= tbl_x[i] && x <= tbl_x[i] + tbl_w[i]) begin
        r.land = 1'b1; r.plt = i; r.ly = tbl_y[i] - 2*H;
      end
    return r;
  endfunction

  // Reference: an accepted start opens a 2*N cycle window, results appear with done when it closes.
  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_done = 1'b0;
      for (int p = 0; p < 2; p++) begin m_out[p].land = 1'b0; m_out[p].plt = 0; m_out[p].ly = 0; end
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin m_done = 1'b1; m_out = m_pend; end
      end else if (start) begin
        m_left = 2*N;
        m_pend[0] = model_land(int'(p1_x), int'(p1_y), int'(p1_next_y));
        m_pend[1] = model_land(int'(p2_x), int'(p2_y), int'(p2_next_y));
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      checks++;
      if (busy !== (m_left > 0) || done !== m_done ||
          p1_land !== m_out[0].land || p1_plt !== 2'(m_out[0].plt) || p1_land_y !== 10'(m_out[0].ly) ||
          p2_land !== m_out[1].land || p2_plt !== 2'(m_out[1].plt) || p2_land_y !== 10'(m_out[1].ly)) begin
        errors++;
        $display("FAIL model_cycle t=%0t got busy=%b done=%b p1=%b/%0d/%0d p2=%b/%0d/%0d expected busy=%b done=%b p1=%b/%0d/%0d p2=%b/%0d/%0d",
                 $time, busy, done, p1_land, p1_plt, p1_land_y, p2_land, p2_plt, p2_land_y,
                 m_left > 0, m_done, m_out[0].land, m_out[0].plt, m_out[0].ly,
                 m_out[1].land, m_out[1].plt, m_out[1].ly);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_pos(input int a, input int b, input int c, input int d, input int e, input int f);
    p1_x = 10'(a); p1_y = 10'(b); p1_next_y = 10'(c);
    p2_x = 10'(d); p2_y = 10'(e); p2_next_y = 10'(f);
  endtask

  // Called at a negedge; returns the number of cycles until done (-1 if it never came).
  task automatic run_scan(output int lat);
    lat = -1;
    start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done === 1'b1) begin lat = i; break; end
    end
  endtask

  function automatic int rand_y();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(900, 1023)) : int'($urandom_range(0, 420));
  endfunction

  function automatic int rand_ny(input int y);
    int v;
    v = ($urandom_range(0, 1) == 0) ? y + int'($urandom_range(0, 250)) : int'($urandom_range(0, 1023));
    return (v > 1023) ? 1023 : v;
  endfunction

  initial begin
    int lat, ndone, y1, y2;

    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_p1_land_y", int'(p1_land_y), 0);
    chk("reset_p2_plt", int'(p2_plt), 0);
    rst = 1'b0;
    @(negedge clk);

    set_pos(150, 150, 160, 600, 0, 5);
    run_scan(lat);
    chk("basic_latency", lat, 9);
    chk("basic_p1_land", int'(p1_land), 1);
    chk("basic_p1_plt", int'(p1_plt), 0);
    chk("basic_p1_land_y", int'(p1_land_y), 155);
    chk("basic_p2_land", int'(p2_land), 0);

    set_pos(150, 100, 330, 300, 100, 330);
    run_scan(lat);
    chk("b2b_latency", lat, 9);
    chk("prio_p1_plt", int'(p1_plt), 0);
    chk("prio_p1_land_y", int'(p1_land_y), 155);
    chk("prio_p2_land", int'(p2_land), 1);
    chk("prio_p2_plt", int'(p2_plt), 3);
    chk("prio_p2_land_y", int'(p2_land_y), 320);

    set_pos(74, 150, 160, 73, 150, 160);
    run_scan(lat);
    chk("xedge_74_land", int'(p1_land), 1);
    chk("xedge_73_land", int'(p2_land), 0);
    set_pos(226, 150, 160, 225, 150, 160);
    run_scan(lat);
    chk("xedge_226_land", int'(p1_land), 0);
    chk("xedge_225_land", int'(p2_land), 1);
    chk("xedge_225_land_y", int'(p2_land_y), 155);

    set_pos(150, 150, 160, 150, 1000, 1023);
    run_scan(lat);
    chk("ovf_1023_p2_land", int'(p2_land), 0);
    chk("ovf_ref_p1_land", int'(p1_land), 1);
    set_pos(150, 150, 160, 150, 1000, 330);
    run_scan(lat);
    chk("ovf_330_p2_land", int'(p2_land), 0);

    // Protocol: mid-scan start and input changes; previous results (p1 plt0 / 155) held until done.
    repeat (2) @(negedge clk);
    set_pos(300, 100, 330, 150, 150, 160);
    start = 1'b1;
    ndone = 0; lat = -1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 2) set_pos(600, 0, 5, 600, 0, 5);
      if (i == 3) start = 1'b1;
      if (i == 4) start = 1'b0;
      if (i == 5) begin
        chk("hold_p1_land", int'(p1_land), 1);
        chk("hold_p1_land_y", int'(p1_land_y), 155);
        chk("hold_p2_land", int'(p2_land), 0);
      end
      if (done === 1'b1) begin ndone++; lat = i; end
    end
    chk("proto_done_count", ndone, 1);
    chk("proto_latency", lat, 9);
    chk("proto_p1_plt", int'(p1_plt), 3);
    chk("proto_p1_land_y", int'(p1_land_y), 320);
    chk("proto_p2_land", int'(p2_land), 1);
    chk("proto_p2_plt", int'(p2_plt), 0);

    // Reset in the middle of a scan.
    set_pos(150, 150, 160, 150, 150, 160);
    start = 1'b1;
    ndone = 0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 5) rst = 1'b1;
      if (i == 6) begin
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_p1_land", int'(p1_land), 0);
        chk("rst_p1_plt", int'(p1_plt), 0);
        chk("rst_p1_land_y", int'(p1_land_y), 0);
      end
      if (done === 1'b1) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    set_pos(74, 150, 160, 600, 0, 5);
    run_scan(lat);
    chk("post_rst_latency", lat, 9);
    chk("post_rst_p1_land", int'(p1_land), 1);

    // Random traffic: starts at any time (including mid-scan and during done), rare resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1) == 0) begin
        y1 = rand_y();
        y2 = rand_y();
        set_pos(int'($urandom_range(0, 700)), y1, rand_ny(y1),
                int'($urandom_range(0, 700)), y2, rand_ny(y2));
      end
    end
    start = 1'b0;
    rst = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
